// File: rtl/aes_shiftrows_row_shifter.sv
// AES encryption-path ShiftRows stage, one N-byte state row per cycle.
// Each row is rotated left by its row index; the row index advances on wr_en
// and wraps after N rows, pulsing done as the last row is retired.
module aes_shiftrows_row_shifter #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              resetn,   // active-high synchronous reset despite the name
    input  logic              wr_en,
    input  logic [N-1:0][7:0] inp,
    output logic [N-1:0][7:0] outp,
    output logic              done
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    logic [RW-1:0]      row_q, row_d;
    logic [N-1:0][7:0]  outp_q, outp_d;
    logic               done_q, done_d;

    // Rotate the incoming row left by the current (pre-update) row index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        outp_d = '0;
        for (int j = 0; j < N; j++) begin
            outp_d[j] = inp[(j + int'(row_q)) % N];
        end
    end

    // Row counter advance/wrap and done pulse on retiring the last row.
    always_comb begin
        row_d  = row_q;
        done_d = 1'b0;
        if (wr_en) begin
            if (row_q == LAST_ROW) begin
                row_d  = '0;
                done_d = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    // State registers; reset wins over any concurrent wr_en.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, regardless of statement order.
        if (resetn) begin
            row_q  <= '0;
            outp_q <= '0;
            done_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            outp_q <= outp_d;
            done_q <= done_d;
        end
    end

    assign outp = outp_q;
    assign done = done_q;

endmodule

// File: tb/tb_aes_shiftrows_row_shifter.sv
// Scoreboard bench for aes_shiftrows_row_shifter: the driver pushes the
// expected registered response for each applied cycle, the monitor pops and
// compares one entry just after every rising edge.
module tb_aes_shiftrows_row_shifter;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0][7:0] outp;
        logic              done;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr_en;
    logic [N-1:0][7:0] inp;
    logic [N-1:0][7:0] outp;
    logic              done;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_seen = 0;
    int   m_row = 0;   // reference model's row index

    aes_shiftrows_row_shifter #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en),
        .inp    (inp),
        .outp   (outp),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: one DUT output per clock, compared against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_seen++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (outp !== e.outp || done !== e.done) begin
                n_err++;
                $display("FAIL cycle@%0t: outp=%h done=%b, expected outp=%h done=%b",
                         $time, outp, done, e.outp, e.done);
            end
        end
    end

    // Drive one cycle of inputs and record what the block must produce.
    task automatic apply(input logic rst, input logic we, input logic [N-1:0][7:0] data);
        exp_t e;
        byte  b[N];
        @(negedge clk);
        resetn = rst;
        wr_en  = we;
        inp    = data;
        if (rst) begin
            e.outp = '0;
            e.done = 1'b0;
            m_row  = 0;
        end else begin
            // Left rotation by m_row: byte array shifted so b[0] is data[m_row].
            for (int k = 0; k < N; k++) b[k] = data[k];
            for (int r = 0; r < m_row; r++) begin
                byte first;
                first = b[0];
                for (int k = 0; k < N - 1; k++) b[k] = b[k+1];
                b[N-1] = first;
            end
            for (int k = 0; k < N; k++) e.outp[k] = b[k];
            e.done = we && (m_row == N - 1);
            if (we) m_row = (m_row + 1) % N;
        end
        sb.push_back(e);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        logic [N-1:0][7:0] seq_row;
        int d0;
        resetn = 1'b1;
        wr_en  = 1'b0;
        seq_row = 32'h03020100;
        inp    = seq_row;

        // Reset held two cycles, then row 0 pass-through.
        apply(1'b1, 1'b0, seq_row);
        apply(1'b1, 1'b0, seq_row);
        apply(1'b0, 1'b0, seq_row);
        apply(1'b0, 1'b0, seq_row);

        // Four single-cycle pulses walk rows 1,2,3 then wrap with done.
        for (int p = 0; p < 4; p++) begin
            apply(1'b0, 1'b1, seq_row);
            apply(1'b0, 1'b0, seq_row);
            apply(1'b0, 1'b0, seq_row);
        end
        drain();

        // Continuous wr_en for 8 cycles: two done pulses.
        d0 = done_seen;
        for (int c = 0; c < 8; c++) apply(1'b0, 1'b1, 32'hDDCCBBAA);
        apply(1'b0, 1'b0, 32'hDDCCBBAA);
        drain();
        check("done_pulses_continuous", done_seen - d0, 2);

        // Reset mid-pass at row 2 concurrent with wr_en.
        apply(1'b0, 1'b1, 32'h11223344);
        apply(1'b0, 1'b1, 32'h11223344);
        apply(1'b1, 1'b1, 32'h11223344);
        apply(1'b0, 1'b0, 32'h11223344);
        apply(1'b0, 1'b0, 32'h11223344);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), $urandom);
        end
        apply(1'b0, 1'b0, '0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_shiftrows_row_shifter.md
Name: aes_shiftrows_row_shifter

Overview:
- Encryption-path ShiftRows stage of the AES-256 core. It processes one 4-byte state row at a time.
- It cyclically rotates the row left by the current row index (0..N-1). An internal row counter advances on each wr_en strobe.
- It feeds the MixColumns/row-assembly logic. done flags completion of a full set of rows.

Parameters:
- N, 4, number of bytes per row. This is also the number of rows per pass; the row counter runs 0..N-1.

Ports:
- clk, input, 1, rising-edge clock. Single clock domain.
- resetn, input, 1, synchronous active-high reset. The codebase port name is kept; a value of 1 resets the block on the next rising clk edge.
- wr_en, input, 1, row-advance strobe, sampled on the rising edge.
- inp, input, [N-1:0][7:0], packed row bytes. inp[0] is byte 0, bits 7:0.
- outp, output, [N-1:0][7:0], registered rotated row.
- done, output, 1, registered one-cycle pulse when the last row (index N-1) is retired.

Behaviour:
- State:
  - row: a ceil(log2 N)-bit counter (2 bits for N=4).
  - outp register.
  - done register.
- Reset: when resetn=1 at a rising edge, row, outp and done all become 0. Reset has priority over wr_en. Reset mid-pass discards progress, and the next pass starts at row 0.
- Datapath, every non-reset rising edge:
  - outp[j] <= inp[(j + row) mod N] for j = 0..N-1, using the row value before that edge's update.
  - Row 0 is a pass-through. Row 1 is a 1-byte left rotate. Row 2 is a 2-byte rotate. Row 3 is a 3-byte rotate.
  - Latency: 1 cycle from inp to outp. outp refreshes every cycle whether or not wr_en is asserted, so a stable inp gives a stable outp.
  - The modulo index is computed with wrap, never out of range. There is no arithmetic on byte values; bytes are moved unchanged.
- Row counter:
  - When wr_en=1 at an edge: if row < N-1, row <= row+1; if row == N-1, row <= 0 (wrap).
  - When wr_en=0 at an edge: row holds.
  - Back-to-back wr_en advances one row per cycle.
  - Holding wr_en high continuously cycles 0,1,2,3,0,...
- done:
  - done <= 1 on an edge where wr_en=1 and row == N-1; otherwise done <= 0.
  - This gives exactly one cycle of done per wrap, coincident with the cycle row reads 0 again.
  - done is never asserted during or immediately after reset.
- Simultaneous events:
  - The edge where wr_en advances the row still computes outp with the old row.
  - The first output using the new row appears on the following edge.
- Unknown or X on wr_en is not supported. The driver holds wr_en at 0 when idle.
- There are no other outputs and no backpressure. The block is always ready.

Test Plan:
- Reset: hold resetn=1 for 2 cycles with inp={03,02,01,00} (byte3..byte0) and wr_en=0 -> outp=0, done=0. After release, one cycle later outp[0..3]=00,01,02,03 (row 0).
- Row 1: pulse wr_en for one cycle, keep inp the same -> from the 2nd edge after the pulse, outp[0..3]=01,02,03,00; done=0.
- Rows 2 and 3: two more single-cycle wr_en pulses -> outp[0..3]=02,03,00,01, then 03,00,01,02.
- Wrap/done: a 4th wr_en pulse while row=3 -> done=1 for exactly one cycle. The next outp is 00,01,02,03, and done returns to 0.
- Continuous wr_en=1 for 8 cycles with inp={DD,CC,BB,AA} -> outp sequence rotates 0,1,2,3,0,1,2,3 (lagging row by 1 cycle); done pulses twice, 4 cycles apart.
- Reset mid-pass: advance to row 2, assert resetn=1 for 1 cycle concurrent with wr_en=1 -> row=0, outp=0, done=0. Next output is a row-0 pass-through.
